obi_data_responder: RTL and testbench
=====================================

OBI_DATA_RESPONDER -- requirements
Module: obi_data_responder

Interface
REQ-001 Parameter DEPTH, default 16, number of 32-bit memory words (power of two, 2..256) SHALL be supported.
REQ-002 Parameter ADDR_BASE, default 32'h0, byte address of word 0 (DEPTH*4 aligned) SHALL be supported.
REQ-003 Parameter GNT_DELAY, default 0, wait cycles between request assertion and grant (0..15) SHALL be supported.
REQ-004 clk_i  input  1  sole clock, all state updates on rising edge.
REQ-005 rst_ni  input  1  reset, synchronous, active-low.
REQ-006 data_req_i  input  1  core request valid.
REQ-007 data_we_i  input  1  1 = write, 0 = read.
REQ-008 data_be_i  input  4  byte enables, bit n selects byte lane n.
REQ-009 data_addr_i  input  32  byte address; bits [1:0] ignored.
REQ-010 data_wdata_i  input  32  write data.
REQ-011 data_gnt_o  output  1  request accepted this cycle (combinational).
REQ-012 data_rvalid_o  output  1  response valid (registered).
REQ-013 data_rdata_o  output  32  read data, valid with rvalid.
REQ-014 data_err_o  output  1  access error, valid with rvalid.
REQ-015 rd_count_o  output  16  accepted reads, saturating.
REQ-016 wr_count_o  output  16  accepted writes, saturating.

Function
REQ-017 FSM states: IDLE, WAIT; 4-bit wait counter cnt.
REQ-018 IDLE: req=1 and GNT_DELAY=0 -> gnt=1 same cycle, stay IDLE; req=1 and GNT_DELAY>0 -> cnt<=1, go WAIT; req=0 -> stay IDLE.
REQ-019 WAIT: gnt=1 when req=1 and cnt==GNT_DELAY, then next state IDLE, cnt<=0; else cnt<=cnt+1.
REQ-020 WAIT with req=0 (withdrawn request) -> IDLE, cnt<=0, no access, no response.
REQ-021 gnt SHALL never be asserted while req=0.
REQ-022 In-range: ADDR_BASE <= addr < ADDR_BASE+4*DEPTH; word index = (addr-ADDR_BASE)>>2.
REQ-023 Granted in-range write: at the grant edge, each lane n with be[n]=1 takes wdata byte n; other lanes unchanged.
REQ-024 Granted in-range read: rdata <= full 32-bit word at index, regardless of be.
REQ-025 Response: rvalid=1 exactly one cycle after grant, for exactly one cycle; otherwise rvalid=0.
REQ-026 Write response: rdata=0, err=0.
REQ-027 Out-of-range access: memory unchanged, rdata=0, err=1 with rvalid.
REQ-028 rdata and err SHALL be 0 whenever rvalid=0.
REQ-029 Back-to-back: a new request may be granted in the rvalid cycle of the previous one; responses stay in order, one per grant.
REQ-030 Read granted the cycle after a write to the same word returns the written data.
REQ-031 rd_count_o/wr_count_o increment by 1 per granted read/write (including erroring ones); hold at 16'hFFFF.

Reset
REQ-032 rst_ni=0 at a rising edge: state IDLE, cnt=0, rvalid=0, rdata=0, err=0, counters=0, all memory words=0.
REQ-033 gnt_o SHALL be 0 during any cycle with rst_ni=0.
REQ-034 Reset mid-WAIT or in a response cycle aborts the transaction: no grant, no rvalid after reset release.
REQ-035 First request accepted in the first cycle with rst_ni=1.

Verification
REQ-036 GNT_DELAY=0: write addr 0x8, be=4'hF, wdata 0xDEADBEEF; then read 0x8 -> gnt same cycle as req, rvalid next cycle, rdata 0xDEADBEEF, err 0; wr_count=1, rd_count=1.
REQ-037 Byte lanes: after 0x8=0xDEADBEEF, write 0x8 be=4'b0101 wdata 0x11223344 -> read 0x8 returns 0xDE22BE44.
REQ-038 GNT_DELAY=3: req held from cycle 0 -> gnt in cycle 3 only, rvalid in cycle 4; req dropped in cycle 2 -> no gnt, no rvalid, FSM IDLE.
REQ-039 DEPTH=16, ADDR_BASE=0: read 0x40 -> rvalid, err=1, rdata=0; write 0x40 -> err=1, reading words 0..15 unchanged; rd_count and wr_count each +1.
REQ-040 Reset: write 0x4=0x5, assert rst_ni=0 during a read-response cycle -> rvalid=0 after release, read 0x4 returns 0, counters 0.
REQ-041 Saturation: 65537 granted reads -> rd_count_o=16'hFFFF, wr_count_o unchanged.

Source files
------------

// File: rtl/obi_data_if.sv
// OBI data-side request/response bus between a core (master) and a memory responder (slave).
interface obi_data_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/obi_data_responder.sv
// OBI data responder: word memory with programmable grant latency, one registered
// response per grant, error on out-of-range accesses, saturating access counters.
module obi_data_responder #(
  parameter int unsigned DEPTH     = 16,
  parameter logic [31:0] ADDR_BASE = 32'h0,
  parameter int unsigned GNT_DELAY = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  obi_data_if.slave   bus,
  output logic [15:0] rd_count_o,
  output logic [15:0] wr_count_o
);
  localparam int unsigned IW = $clog2(DEPTH);
  localparam logic [3:0]  GD = 4'(GNT_DELAY);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic [DEPTH-1:0][31:0]  mem;
  logic [31:0]             offset;
  logic                    in_range;
  logic [IW-1:0]           idx;
  logic                    unused_offset;

  // Unsigned subtraction makes addresses below ADDR_BASE wrap high and fall out of range.
  assign offset        = bus.addr - ADDR_BASE;
  assign in_range      = (offset >> (IW + 2)) == 32'd0;
  assign idx           = offset[IW+1:2];
  assign unused_offset = ^offset[1:0];

  always_comb begin
    bus.gnt = 1'b0;
    if (rst_ni && bus.req) begin
      if (GD == 4'd0) bus.gnt = (state == IDLE);
      else            bus.gnt = (state == WAIT) && (cnt == GD);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= IDLE;
      cnt        <= '0;
      bus.rvalid <= 1'b0;
      bus.rdata  <= '0;
      bus.err    <= 1'b0;
      rd_count_o <= '0;
      wr_count_o <= '0;
      mem        <= '0;
    end else begin
      bus.rvalid <= bus.gnt;
      bus.rdata  <= '0;
      bus.err    <= bus.gnt && !in_range;

      case (state)
        IDLE: if (bus.req && GD != 4'd0) begin
          state <= WAIT;
          cnt   <= 4'd1;
        end
        WAIT: if (!bus.req || cnt == GD) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 4'd1;
        end
      endcase

      if (bus.gnt) begin
        if (bus.we) begin
          if (wr_count_o != 16'hFFFF) wr_count_o <= wr_count_o + 16'd1;
          if (in_range) begin
            for (int n = 0; n < 4; n++)
              if (bus.be[n]) mem[idx][8*n +: 8] <= bus.wdata[8*n +: 8];
          end
        end else begin
          if (rd_count_o != 16'hFFFF) rd_count_o <= rd_count_o + 16'd1;
          if (in_range) bus.rdata <= mem[idx];
        end
      end
    end
  end
endmodule

// File: tb/tb_obi_data_responder.sv
// Bench for obi_data_responder: zero-latency instance checked through a response
// scoreboard, plus a GNT_DELAY=3 instance checked cycle by cycle.
module tb_obi_data_responder;
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst0_n, rst3_n;
  logic [15:0] rd0_cnt, wr0_cnt, rd3_cnt, wr3_cnt;
  obi_data_if  b0 ();
  obi_data_if  b3 ();

  int          total = 0;
  int          bad = 0;
  bit          mon_en = 1'b0;
  rsp_t        q0[$];
  rsp_t        mr;
  logic [31:0] m0 [16];
  logic [15:0] rd0, wr0;

  always #5 clk = ~clk;

  obi_data_responder #(.DEPTH(16), .ADDR_BASE(32'h0), .GNT_DELAY(0)) u_d0 (
    .clk_i(clk), .rst_ni(rst0_n), .bus(b0), .rd_count_o(rd0_cnt), .wr_count_o(wr0_cnt));

  obi_data_responder #(.DEPTH(16), .ADDR_BASE(32'h0), .GNT_DELAY(3)) u_d3 (
    .clk_i(clk), .rst_ni(rst3_n), .bus(b3), .rd_count_o(rd3_cnt), .wr_count_o(wr3_cnt));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Response scoreboard: each rvalid pops the oldest expected response.
  always @(negedge clk) begin
    if (mon_en) begin
      if (b0.rvalid === 1'b1) begin
        if (q0.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          mr = q0.pop_front();
          chk("rsp_rdata", b0.rdata, mr.rdata);
          chk("rsp_err", b0.err, mr.err);
        end
      end else begin
        chk("rvalid_low", b0.rvalid, 0);
        chk("idle_zero", {b0.rdata, b0.err}, 33'd0);
      end
    end
  end

  task automatic acc0_now(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd);
    rsp_t r;
    logic inr;
    b0.req = 1'b1; b0.we = we; b0.addr = addr; b0.be = be; b0.wdata = wd;
    #1;
    chk("gnt0", b0.gnt, 1);
    inr     = addr < 32'h40;
    r.err   = !inr;
    r.rdata = '0;
    if (we) begin
      if (wr0 != 16'hFFFF) wr0++;
      if (inr)
        for (int n = 0; n < 4; n++)
          if (be[n]) m0[addr[5:2]][8*n +: 8] = wd[8*n +: 8];
    end else begin
      if (rd0 != 16'hFFFF) rd0++;
      if (inr) r.rdata = m0[addr[5:2]];
    end
    q0.push_back(r);
  endtask

  task automatic acc0(input logic we, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] wd);
    @(negedge clk);
    acc0_now(we, addr, be, wd);
  endtask

  task automatic idle0(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      b0.req = 1'b0;
      #1;
      chk("gnt_noreq", b0.gnt, 0);
    end
  endtask

  task automatic chk_cnt0();
    chk("rd_count0", rd0_cnt, rd0);
    chk("wr_count0", wr0_cnt, wr0);
  endtask

  // Request held from cycle 0: grant only in cycle 3, response in cycle 4.
  task automatic d3_held(input string tag);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) begin b3.req = 1'b1; b3.we = 1'b0; b3.addr = 32'h4; b3.be = 4'hF; end
      if (c == 4) b3.req = 1'b0;
      #1;
      chk({tag, "_gnt"}, b3.gnt, c == 3);
      chk({tag, "_rvalid"}, b3.rvalid, c == 4);
      if (c == 4) chk({tag, "_rsp"}, {b3.rdata, b3.err}, 33'd0);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst0_n = 1'b0; rst3_n = 1'b0;
    b0.req = 1'b0; b0.we = 1'b0; b0.be = '0; b0.addr = '0; b0.wdata = '0;
    b3.req = 1'b0; b3.we = 1'b0; b3.be = '0; b3.addr = '0; b3.wdata = '0;
    for (int i = 0; i < 16; i++) m0[i] = '0;
    rd0 = '0; wr0 = '0;
    repeat (3) @(negedge clk);
    chk("rst_rsp0", {b0.rvalid, b0.rdata, b0.err}, 34'd0);
    chk("rst_cnt0", {rd0_cnt, wr0_cnt}, 32'd0);
    chk("rst_rsp3", {b3.rvalid, b3.rdata, b3.err}, 34'd0);
    chk("rst_cnt3", {rd3_cnt, wr3_cnt}, 32'd0);
    rst0_n = 1'b1; rst3_n = 1'b1;
    mon_en = 1'b1;

    // Full-word write then read, then byte-lane merge.
    acc0(1'b1, 32'h8, 4'hF, 32'hDEADBEEF);
    acc0(1'b0, 32'h8, 4'hF, 32'h0);
    idle0(1);
    chk_cnt0();
    acc0(1'b1, 32'h8, 4'b0101, 32'h11223344);
    acc0(1'b0, 32'h8, 4'h0, 32'h0);
    acc0(1'b0, 32'h9, 4'h1, 32'h0);
    acc0(1'b1, 32'h3C, 4'b0011, 32'hCAFEF00D);
    acc0(1'b0, 32'h3C, 4'hF, 32'h0);
    acc0(1'b1, 32'h0, 4'b1000, 32'hA5000000);
    idle0(2);

    // Out-of-range read and write, then sweep all words.
    acc0(1'b0, 32'h40, 4'hF, 32'h0);
    acc0(1'b1, 32'h40, 4'hF, 32'hFFFFFFFF);
    acc0(1'b1, 32'hFFFF_FFFC, 4'hF, 32'h12345678);
    for (int i = 0; i < 16; i++) acc0(1'b0, 32'(i * 4), 4'hF, 32'h0);
    idle0(2);
    chk_cnt0();

    // Reset asserted during a read-response cycle.
    acc0(1'b1, 32'h4, 4'hF, 32'h5);
    acc0(1'b0, 32'h4, 4'hF, 32'h0);
    @(negedge clk);
    #1 rst0_n = 1'b0;
    #1 chk("gnt_in_rst", b0.gnt, 0);
    @(negedge clk);
    #1;
    chk("gnt_in_rst2", b0.gnt, 0);
    chk("rvalid_after_rst", b0.rvalid, 0);
    for (int i = 0; i < 16; i++) m0[i] = '0;
    rd0 = '0; wr0 = '0;
    chk_cnt0();
    @(negedge clk);
    rst0_n = 1'b1;
    acc0_now(1'b0, 32'h4, 4'hF, 32'h0);
    idle0(2);
    chk_cnt0();

    // Delayed-grant instance: held request, then withdrawn request, then held again.
    d3_held("d3_held");
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) begin b3.req = 1'b1; b3.we = 1'b0; b3.addr = 32'h4; end
      if (c == 2) b3.req = 1'b0;
      #1;
      chk("d3_drop_gnt", b3.gnt, 0);
      chk("d3_drop_rvalid", b3.rvalid, 0);
    end
    d3_held("d3_after_drop");
    chk("d3_rd_count", rd3_cnt, 16'd2);
    chk("d3_wr_count", wr3_cnt, 16'd0);

    // Read counter saturation with back-to-back grants.
    for (int i = 0; i < 65537; i++) acc0(1'b0, 32'h0, 4'hF, 32'h0);
    idle0(3);
    chk("rd_sat", rd0_cnt, 16'hFFFF);
    chk_cnt0();
    chk("queue_empty", q0.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
